// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode/execute definitions: data width, jump classes, fetch FSM states.
package fetch_unit_pkg;

    localparam int DWIDTH = 32;

    // Control-flow class of an instruction, produced by the decoder.
    typedef enum logic [2:0] {
        JT_NONE = 3'b000,
        JT_BEQ  = 3'b001,
        JT_JAL  = 3'b010,
        JT_JR   = 3'b011,
        JT_J    = 3'b100
    } jump_type_t;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        REQ  = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/next_pc_calc.sv
// Purely combinational next-PC selection for the instruction held by fetch_unit.
module next_pc_calc #(
    parameter int DWIDTH = fetch_unit_pkg::DWIDTH
) (
    input  logic [DWIDTH-1:0] instr_pc4,
    input  logic [2:0]        jump_type,
    input  logic [25:0]       jump_addr,
    input  logic [DWIDTH-1:0] imm,
    input  logic [DWIDTH-1:0] rs1_data,
    input  logic              alu_zero,
    output logic [DWIDTH-1:0] next_pc,
    output logic              misaligned
);
    import fetch_unit_pkg::*;

    // Select the successor address; unknown jump classes fall through sequentially.
    always_comb begin
        next_pc    = instr_pc4;
        misaligned = 1'b0;
        case (jump_type)
            JT_BEQ: begin
                if (alu_zero) begin
                    next_pc = instr_pc4 + (imm << 2);
                end
            end
            JT_JAL, JT_J: begin
                next_pc = {instr_pc4[DWIDTH-1 -: 4], jump_addr, 2'b00};
            end
            JT_JR: begin
                // Low bits are forced to zero; the caller reports the misalignment.
                next_pc    = {rs1_data[DWIDTH-1:2], 2'b00};
                misaligned = |rs1_data[1:0];
            end
            default: begin
                next_pc = instr_pc4;
            end
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time, holds it for decode.
//
// Handshake rules: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both 1; once raised, imem_req_valid and imem_req_addr stay
// stable until that transfer. The response channel is valid-only (one-cycle
// strobe, no backpressure). The held instruction transfers downstream on an edge
// where instr_valid and instr_ready are both 1; instr/instr_pc/instr_pc4 are
// stable until then.
module fetch_unit #(
    parameter int                 DWIDTH   = fetch_unit_pkg::DWIDTH,
    parameter logic [DWIDTH-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    output logic [DWIDTH-1:0] imem_req_addr,
    input  logic              imem_req_ready,
    input  logic              imem_rsp_valid,
    input  logic [DWIDTH-1:0] imem_rsp_data,
    output logic [DWIDTH-1:0] instr,
    output logic              instr_valid,
    output logic [DWIDTH-1:0] instr_pc,
    output logic [DWIDTH-1:0] instr_pc4,
    input  logic              instr_ready,
    input  logic [2:0]        jump_type,
    input  logic [25:0]       jump_addr,
    input  logic [DWIDTH-1:0] imm,
    input  logic [DWIDTH-1:0] rs1_data,
    input  logic              alu_zero,
    output logic              addr_err
);
    import fetch_unit_pkg::*;

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [DWIDTH-1:0] pc;
    logic              drop_pending;
    logic              req_fire;
    logic              rsp_take;
    logic              rsp_drop;
    logic              instr_fire;
    logic [DWIDTH-1:0] next_pc;
    logic              misaligned;

    assign imem_req_addr = pc;

    next_pc_calc #(
        .DWIDTH(DWIDTH)
    ) u_next_pc_calc (
        .instr_pc4  (instr_pc4),
        .jump_type  (jump_type),
        .jump_addr  (jump_addr),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .alu_zero   (alu_zero),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // Next-state decode and the per-cycle events that move the sequencer.
    always_comb begin
        state_next = state;
        req_fire   = 1'b0;
        rsp_take   = 1'b0;
        rsp_drop   = 1'b0;
        instr_fire = 1'b0;
        case (state)
            REQ: begin
                if (imem_req_valid && imem_req_ready) begin
                    req_fire   = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop_pending) begin
                        // Response belongs to a request abandoned by reset: refetch.
                        rsp_drop   = 1'b1;
                        state_next = REQ;
                    end else begin
                        rsp_take   = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (instr_valid && instr_ready) begin
                    instr_fire = 1'b1;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = REQ;
            end
        endcase
    end

    // State, PC and registered outputs; drop_pending survives reset by design.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= REQ;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            instr          <= '0;
            instr_valid    <= 1'b0;
            instr_pc       <= RESET_PC;
            instr_pc4      <= RESET_PC + DWIDTH'(4);
            addr_err       <= 1'b0;
            drop_pending   <= (state == WAIT);
        end else begin
            state          <= state_next;
            imem_req_valid <= (state_next == REQ);
            instr_valid    <= (state_next == HOLD);
            addr_err       <= instr_fire && misaligned;
            if (rsp_drop) begin
                drop_pending <= 1'b0;
            end
            if (rsp_take) begin
                instr     <= imem_rsp_data;
                instr_pc  <= pc;
                instr_pc4 <= pc + DWIDTH'(4);
            end
            if (instr_fire) begin
                pc <= next_pc;
            end
        end
    end

    // req_fire is kept as a named event for checker binding.
    logic unused_req_fire;
    assign unused_req_fire = req_fire;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed control-flow cases plus randomized fetches.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        instr_ready;
    logic [2:0]  jump_type;
    logic [25:0] jump_addr;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        alu_zero;
    logic        addr_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    fetch_unit #(
        .DWIDTH   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .instr_pc       (instr_pc),
        .instr_pc4      (instr_pc4),
        .instr_ready    (instr_ready),
        .jump_type      (jump_type),
        .jump_addr      (jump_addr),
        .imm            (imm),
        .rs1_data       (rs1_data),
        .alu_zero       (alu_zero),
        .addr_err       (addr_err)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference successor address, from the architectural jump rules.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [2:0] jt,
                                               input logic [25:0] ja, input logic [31:0] off,
                                               input logic [31:0] rs1, input logic z);
        logic [31:0] pc4;
        pc4 = pc + 32'd4;
        if (jt == 3'd1)                 return z ? pc4 + off * 32'd4 : pc4;
        if (jt == 3'd2 || jt == 3'd4)   return (pc4 & 32'hF000_0000) + 32'(ja) * 32'd4;
        if (jt == 3'd3)                 return rs1 - (rs1 % 32'd4);
        return pc4;
    endfunction

    task automatic idle_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        instr_ready    = 1'b0;
        jump_type      = '0;
        jump_addr      = '0;
        imm            = '0;
        rs1_data       = '0;
        alu_zero       = 1'b0;
    endtask

    task automatic wait_req(output int seen);
        int n;
        n = 0;
        while (!imem_req_valid && n < 16) begin
            tick();
            n++;
        end
        seen = n;
    endtask

    // One complete fetch: request (with stalls), response, hold, acceptance.
    task automatic do_fetch(input logic [31:0] data, input int stall, input int dly, input int hold,
                            input logic [2:0] jt, input logic [25:0] ja, input logic [31:0] off,
                            input logic [31:0] rs1, input logic z);
        logic [31:0] a;
        logic [31:0] nxt;
        int          seen;
        a = exp_q.pop_front();
        wait_req(seen);
        check("req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("req_addr", imem_req_addr, a);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", {31'b0, imem_req_valid}, 32'd1);
            check("stall_addr", imem_req_addr, a);
        end
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < dly; i++) begin
            check("wait_ivalid", {31'b0, instr_valid}, 32'd0);
            check("wait_reqvalid", {31'b0, imem_req_valid}, 32'd0);
            tick();
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        tick();
        imem_rsp_valid = 1'b0;
        check("ivalid_rise", {31'b0, instr_valid}, 32'd1);
        check("instr", instr, data);
        check("instr_pc", instr_pc, a);
        check("instr_pc4", instr_pc4, a + 32'd4);
        for (int i = 0; i < hold; i++) begin
            // Stray response strobes and garbage control fields must not matter here.
            imem_rsp_valid = ($urandom_range(0, 1) == 1);
            imem_rsp_data  = $urandom;
            jump_type      = 3'($urandom_range(0, 7));
            rs1_data       = $urandom;
            tick();
            imem_rsp_valid = 1'b0;
            check("hold_ivalid", {31'b0, instr_valid}, 32'd1);
            check("hold_instr", instr, data);
            check("hold_pc", instr_pc, a);
            check("hold_reqvalid", {31'b0, imem_req_valid}, 32'd0);
        end
        jump_type   = jt;
        jump_addr   = ja;
        imm         = off;
        rs1_data    = rs1;
        alu_zero    = z;
        instr_ready = 1'b1;
        tick();
        idle_inputs();
        nxt = model_next(a, jt, ja, off, rs1, z);
        check("ivalid_drop", {31'b0, instr_valid}, 32'd0);
        check("next_reqvalid", {31'b0, imem_req_valid}, 32'd1);
        check("next_addr", imem_req_addr, nxt);
        check("addr_err", {31'b0, addr_err}, {31'b0, (jt == 3'd3) && (rs1 % 32'd4 != 0)});
        tick();
        check("addr_err_end", {31'b0, addr_err}, 32'd0);
        exp_q.push_back(nxt);
    endtask

    initial begin
        logic [31:0] a;
        int          seen;
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_reqvalid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_ivalid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_instr_pc4", instr_pc4, 32'h4);
        check("rst_addr_err", {31'b0, addr_err}, 32'd0);
        exp_q.push_back(32'h0);

        // Sequential fetches 0x0..0xC, then stalls at 0x10.
        do_fetch(32'hA000_0000, 0, 0, 0, 3'd0, 26'h0, 32'h0, 32'h0, 1'b0);
        do_fetch(32'hA000_0004, 0, 0, 0, 3'd0, 26'h0, 32'h0, 32'h0, 1'b0);
        do_fetch(32'hA000_0008, 0, 0, 0, 3'd0, 26'h0, 32'h0, 32'h0, 1'b0);
        do_fetch(32'hA000_000C, 0, 0, 0, 3'd0, 26'h0, 32'h0, 32'h0, 1'b0);
        do_fetch(32'hA000_0010, 4, 0, 3, 3'd0, 26'h0, 32'h0, 32'h0, 1'b0);
        do_fetch(32'hA000_0014, 0, 1, 0, 3'd0, 26'h0, 32'h0, 32'h0, 1'b0);
        do_fetch(32'hA000_0018, 0, 0, 0, 3'd0, 26'h0, 32'h0, 32'h0, 1'b0);
        do_fetch(32'hA000_001C, 0, 0, 0, 3'd0, 26'h0, 32'h0, 32'h0, 1'b0);
        // BEQ at 0x20, taken then not taken.
        do_fetch(32'hB000_0020, 0, 0, 0, 3'd1, 26'h0, 32'hFFFF_FFFE, 32'h0, 1'b1);
        do_fetch(32'hA000_001C, 0, 0, 0, 3'd0, 26'h0, 32'h0, 32'h0, 1'b0);
        do_fetch(32'hB000_0020, 0, 0, 0, 3'd1, 26'h0, 32'hFFFF_FFFE, 32'h0, 1'b0);
        // JR to 0x8000_0040, J to 0x8000_0400, misaligned JR to 0x100, JR to 0x30.
        do_fetch(32'hC000_0024, 0, 0, 0, 3'd3, 26'h0, 32'h0, 32'h8000_0040, 1'b0);
        do_fetch(32'hD000_0040, 0, 0, 1, 3'd4, 26'h000_0100, 32'h0, 32'h0, 1'b0);
        do_fetch(32'hC000_0400, 0, 0, 0, 3'd3, 26'h0, 32'h0, 32'h0000_0103, 1'b0);
        do_fetch(32'hC000_0100, 0, 0, 0, 3'd3, 26'h0, 32'h0, 32'h0000_0030, 1'b0);

        // Reset while waiting for 0x30; stale response must be discarded.
        a = exp_q.pop_front();
        wait_req(seen);
        check("rw_req_addr", imem_req_addr, a);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rw_reqvalid0", {31'b0, imem_req_valid}, 32'd0);
        check("rw_ivalid", {31'b0, instr_valid}, 32'd0);
        check("rw_instr_pc", instr_pc, 32'h0);
        tick();
        check("rw_reqvalid1", {31'b0, imem_req_valid}, 32'd1);
        check("rw_restart_addr", imem_req_addr, 32'h0);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_0030;
        tick();
        imem_rsp_valid = 1'b0;
        check("rw_stale_ivalid", {31'b0, instr_valid}, 32'd0);
        check("rw_reissue_valid", {31'b0, imem_req_valid}, 32'd1);
        check("rw_reissue_addr", imem_req_addr, 32'h0);
        exp_q.delete();
        exp_q.push_back(32'h0);
        do_fetch(32'h600D_0000, 0, 0, 0, 3'd0, 26'h0, 32'h0, 32'h0, 1'b0);

        // Randomized fetches across all jump classes, including undefined codes.
        for (int k = 0; k < 40; k++) begin
            do_fetch($urandom, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                     3'($urandom_range(0, 7)), 26'($urandom),
                     32'($urandom_range(0, 63)) - 32'd32, $urandom, ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
